run_supervisor: RTL and testbench
=================================

Name: run_supervisor

Overview:
- Synthesizable run controller placed beside a Processor instance in example benches and FPGA bring-up tops.
- Sequences the core's reset and counts cycles and retired PCs.
- Detects program completion by either a branch-to-self loop or a match on a programmed halt PC.
- Aborts on a cycle timeout, so benches report a pass/timeout status instead of running a fixed cycle count.

Parameters:
PC_WIDTH, 32, width of monitored program counter
CNT_WIDTH, 32, width of cycle_count and instr_count
RESET_CYCLES, 2, cycles core_nrst is held low after start (min 1)
TIMEOUT_CYCLES, 100000, RUN cycles before timeout (min 1, must fit CNT_WIDTH)
HALT_REPEAT, 4, consecutive identical valid PCs that signal a self-loop halt (min 2)

Ports:
clk  input  1  system clock, rising edge
nrst  input  1  asynchronous active-low reset
start  input  1  one-cycle request to (re)start a run
halt_mode  input  1  0 = self-loop detection, 1 = PC match; sampled on accepted start
halt_pc  input  PC_WIDTH  halt address for mode 1; sampled on accepted start
pc  input  PC_WIDTH  core fetch/retire PC
pc_valid  input  1  pc is valid this cycle (one retired instruction)
core_nrst  output  1  reset to Processor, active-low
busy  output  1  high in RESET and RUN
done  output  1  run ended by halt detection
timed_out  output  1  run ended by timeout
cycle_count  output  CNT_WIDTH  RUN cycles elapsed
instr_count  output  CNT_WIDTH  pc_valid cycles seen in RUN

Behaviour:
- One clock; reset is asynchronous and active-low (nrst); all state is on the rising clk edge.
- nrst low -> state IDLE:
  - core_nrst=0, busy=0, done=0, timed_out=0.
  - cycle_count=0, instr_count=0, repeat counter=0, latched mode/halt_pc=0.
- States IDLE, RESET, RUN, DONE, TIMEOUT.
- IDLE/DONE/TIMEOUT + start=1 -> RESET next cycle:
  - Latch halt_mode and halt_pc.
  - Clear done, timed_out, both counts, the repeat counter and the previous-PC register.
- start is ignored in RESET and RUN.
- RESET:
  - core_nrst=0 for exactly RESET_CYCLES cycles, then RUN.
  - core_nrst rises on the first RUN cycle.
  - pc/pc_valid are ignored in RESET.
- RUN:
  - core_nrst=1.
  - cycle_count += 1 every cycle.
  - instr_count += 1 on each pc_valid.
  - Both counts saturate at all-ones and never wrap.
- Halt mode 0:
  - On a pc_valid cycle where pc equals the previous valid PC, repeat counter += 1.
  - On a pc_valid cycle with a different pc, repeat counter = 1 and the previous PC is updated.
  - The first valid PC of a run sets repeat counter = 1.
  - Cycles with pc_valid=0 leave both unchanged.
  - Halt when repeat counter would reach HALT_REPEAT.
- Halt mode 1: halt on any pc_valid cycle with pc == latched halt_pc.
- The halting cycle's pc_valid is counted in instr_count and its cycle in cycle_count.
- Next state on halt is DONE, with done=1 from the following cycle.
- Timeout: if no halt occurs and this RUN cycle is the TIMEOUT_CYCLES-th (cycle_count == TIMEOUT_CYCLES-1 before increment), next state is TIMEOUT with timed_out=1.
- Halt and timeout on the same cycle -> DONE; halt has priority.
- DONE/TIMEOUT:
  - core_nrst stays 1, so memory state is preserved for dumps.
  - busy=0; counts frozen; flag held until next accepted start or nrst.
- done and timed_out are never high together.
- nrst asserted mid-run returns to IDLE immediately and drives core_nrst low asynchronously.
- Outputs are registered; no combinational input-to-output path.

Test Plan:
- nrst low, then high; pulse start -> core_nrst low exactly 2 cycles, then high; busy high from the cycle after start.
- Mode 0; pc_valid every cycle with pc = 0,4,8,12, then 12 repeated -> done=1 after the 4th consecutive 12; instr_count=7; timed_out=0.
- Mode 1, halt_pc=0x40; PCs stepping by 4 from 0 with pc_valid every other cycle -> done when pc=0x40; instr_count=17; cycle_count=33.
- TIMEOUT_CYCLES=10; PCs never repeat -> timed_out=1, cycle_count=10, done=0; start again -> flags and counts clear, RESET re-entered.
- Halt PC presented on RUN cycle 10 with TIMEOUT_CYCLES=10 -> done=1, timed_out=0; start pulsed during RUN -> no effect.
- nrst pulsed low mid-RUN -> all outputs immediately at reset values and state IDLE; CNT_WIDTH=4 with a long run -> counts saturate at 15.

Source files
------------

// File: rtl/run_supervisor.sv
// Run supervisor for a Processor instance. It holds the core in reset after a start request
// and counts RUN cycles and retired instructions. A run ends on a halt, which is either a
// branch-to-self loop or a match on a programmed PC, or on a cycle timeout.
module run_supervisor #(
    parameter int unsigned PC_WIDTH       = 32,
    parameter int unsigned CNT_WIDTH      = 32,
    parameter int unsigned RESET_CYCLES   = 2,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned HALT_REPEAT    = 4
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 start,
    input  logic                 halt_mode,
    input  logic [PC_WIDTH-1:0]  halt_pc,
    input  logic [PC_WIDTH-1:0]  pc,
    input  logic                 pc_valid,
    output logic                 core_nrst,
    output logic                 busy,
    output logic                 done,
    output logic                 timed_out,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] instr_count
);

    localparam int unsigned RepW = $clog2(HALT_REPEAT + 1);
    localparam int unsigned RstW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    localparam logic [RepW-1:0]      RepHalt = RepW'(HALT_REPEAT);
    localparam logic [RstW-1:0]      RstLast = RstW'(RESET_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CntMax  = '1;

    typedef enum logic [2:0] {
        StIdle,
        StReset,
        StRun,
        StDone,
        StTimeout
    } state_e;

    state_e               state_q;
    logic                 core_nrst_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 timed_out_q;
    logic [CNT_WIDTH-1:0] cycle_count_q;
    logic [CNT_WIDTH-1:0] instr_count_q;
    logic [RepW-1:0]      rep_q;
    logic [PC_WIDTH-1:0]  prev_pc_q;
    logic                 mode_q;
    logic [PC_WIDTH-1:0]  halt_pc_q;
    logic [RstW-1:0]      rst_cnt_q;

    logic [CNT_WIDTH-1:0] cycle_count_d;
    logic [CNT_WIDTH-1:0] instr_count_d;
    logic [RepW-1:0]      rep_d;
    logic [PC_WIDTH-1:0]  prev_pc_d;
    logic                 halt_hit;
    logic                 timeout_hit;

    // Saturating counts and halt/timeout detection for the current RUN cycle
    always_comb begin
        cycle_count_d = (cycle_count_q == CntMax) ? cycle_count_q
                                                  : cycle_count_q + CNT_WIDTH'(1);
        instr_count_d = (instr_count_q == CntMax) ? instr_count_q
                                                  : instr_count_q + CNT_WIDTH'(1);
        rep_d     = rep_q;
        prev_pc_d = prev_pc_q;
        if (pc_valid) begin
            // rep_q == 0 means no valid PC seen yet this run, so prev_pc_q is meaningless
            if ((rep_q != '0) && (pc == prev_pc_q)) begin
                rep_d = rep_q + RepW'(1);
            end else begin
                rep_d     = RepW'(1);
                prev_pc_d = pc;
            end
        end
        halt_hit    = pc_valid && (mode_q ? (pc == halt_pc_q) : (rep_d == RepHalt));
        timeout_hit = (cycle_count_q == CntLast);
    end

    // Run sequencing FSM with registered outputs
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q       <= StIdle;
            core_nrst_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timed_out_q   <= 1'b0;
            cycle_count_q <= '0;
            instr_count_q <= '0;
            rep_q         <= '0;
            prev_pc_q     <= '0;
            mode_q        <= 1'b0;
            halt_pc_q     <= '0;
            rst_cnt_q     <= '0;
        end else begin
            unique case (state_q)
                StIdle, StDone, StTimeout: begin
                    if (start) begin
                        state_q       <= StReset;
                        core_nrst_q   <= 1'b0;
                        busy_q        <= 1'b1;
                        done_q        <= 1'b0;
                        timed_out_q   <= 1'b0;
                        cycle_count_q <= '0;
                        instr_count_q <= '0;
                        rep_q         <= '0;
                        prev_pc_q     <= '0;
                        mode_q        <= halt_mode;
                        halt_pc_q     <= halt_pc;
                        rst_cnt_q     <= '0;
                    end
                end
                StReset: begin
                    if (rst_cnt_q == RstLast) begin
                        state_q     <= StRun;
                        core_nrst_q <= 1'b1;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + RstW'(1);
                    end
                end
                StRun: begin
                    cycle_count_q <= cycle_count_d;
                    if (pc_valid) begin
                        instr_count_q <= instr_count_d;
                    end
                    if (!mode_q) begin
                        rep_q     <= rep_d;
                        prev_pc_q <= prev_pc_d;
                    end
                    // Halt wins over a timeout landing on the same cycle
                    if (halt_hit) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (timeout_hit) begin
                        state_q     <= StTimeout;
                        busy_q      <= 1'b0;
                        timed_out_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign core_nrst   = core_nrst_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timed_out   = timed_out_q;
    assign cycle_count = cycle_count_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_run_supervisor.sv
// Directed bench for run_supervisor. Three instances share one set of inputs: default
// parameters (a), a 10-cycle timeout (b), and 4-bit counters with a 16-cycle timeout (c).
module tb_run_supervisor;

    logic        clk = 1'b0;
    logic        nrst;
    logic        start;
    logic        halt_mode;
    logic [31:0] halt_pc;
    logic [31:0] pc;
    logic        pc_valid;

    logic        core_nrst_a, busy_a, done_a, to_a;
    logic [31:0] cyc_a, ins_a;
    logic        core_nrst_b, busy_b, done_b, to_b;
    logic [31:0] cyc_b, ins_b;
    logic        core_nrst_c, busy_c, done_c, to_c;
    logic [3:0]  cyc_c, ins_c;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    run_supervisor u_dut_a (
        .clk(clk), .nrst(nrst), .start(start), .halt_mode(halt_mode), .halt_pc(halt_pc),
        .pc(pc), .pc_valid(pc_valid), .core_nrst(core_nrst_a), .busy(busy_a),
        .done(done_a), .timed_out(to_a), .cycle_count(cyc_a), .instr_count(ins_a)
    );

    run_supervisor #(.TIMEOUT_CYCLES(10)) u_dut_b (
        .clk(clk), .nrst(nrst), .start(start), .halt_mode(halt_mode), .halt_pc(halt_pc),
        .pc(pc), .pc_valid(pc_valid), .core_nrst(core_nrst_b), .busy(busy_b),
        .done(done_b), .timed_out(to_b), .cycle_count(cyc_b), .instr_count(ins_b)
    );

    run_supervisor #(.CNT_WIDTH(4), .TIMEOUT_CYCLES(16)) u_dut_c (
        .clk(clk), .nrst(nrst), .start(start), .halt_mode(halt_mode), .halt_pc(halt_pc),
        .pc(pc), .pc_valid(pc_valid), .core_nrst(core_nrst_c), .busy(busy_c),
        .done(done_c), .timed_out(to_c), .cycle_count(cyc_c), .instr_count(ins_c)
    );

    typedef struct {
        logic        start;
        logic        mode;
        logic [31:0] hpc;
        logic [31:0] pc;
        logic        valid;
        logic        e_nrst;
        logic        e_busy;
        logic        e_done;
        logic        e_to;
        int          e_cyc;
        int          e_ins;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Mode 0 self-loop run on instance a, one row per clock
        vecs[0]  = '{1'b1, 1'b0, 32'h0, 32'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0, 32'd12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0};
        vecs[2]  = '{1'b0, 1'b0, 32'h0, 32'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0};
        vecs[3]  = '{1'b0, 1'b0, 32'h0, 32'd0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1};
        vecs[4]  = '{1'b1, 1'b1, 32'h0, 32'd4,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2, 2};
        vecs[5]  = '{1'b0, 1'b0, 32'h0, 32'd8,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3, 3};
        vecs[6]  = '{1'b0, 1'b0, 32'h0, 32'd12, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4, 4};
        vecs[7]  = '{1'b0, 1'b0, 32'h0, 32'd12, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5, 5};
        vecs[8]  = '{1'b0, 1'b0, 32'h0, 32'd99, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6, 5};
        vecs[9]  = '{1'b0, 1'b0, 32'h0, 32'd12, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 7, 6};
        vecs[10] = '{1'b0, 1'b0, 32'h0, 32'd12, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8, 7};
        vecs[11] = '{1'b0, 1'b0, 32'h0, 32'd12, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8, 7};

        nrst = 1'b0; start = 1'b0; halt_mode = 1'b0; halt_pc = '0; pc = '0; pc_valid = 1'b0;
        tick();
        tick();
        check("rst_core_nrst", 64'(core_nrst_a), 64'd0);
        check("rst_busy",      64'(busy_a),      64'd0);
        check("rst_done",      64'(done_a),      64'd0);
        check("rst_timed_out", 64'(to_a),        64'd0);
        check("rst_cycles",    64'(cyc_a),       64'd0);
        check("rst_instrs",    64'(ins_a),       64'd0);
        nrst = 1'b1;
        tick();
        check("idle_busy", 64'(busy_a), 64'd0);

        for (int i = 0; i < 12; i++) begin
            start = vecs[i].start; halt_mode = vecs[i].mode; halt_pc = vecs[i].hpc;
            pc = vecs[i].pc; pc_valid = vecs[i].valid;
            tick();
            check($sformatf("v%0d_core_nrst", i), 64'(core_nrst_a), 64'(vecs[i].e_nrst));
            check($sformatf("v%0d_busy", i),      64'(busy_a),      64'(vecs[i].e_busy));
            check($sformatf("v%0d_done", i),      64'(done_a),      64'(vecs[i].e_done));
            check($sformatf("v%0d_timed_out", i), 64'(to_a),        64'(vecs[i].e_to));
            check($sformatf("v%0d_cycles", i),    64'(cyc_a),       64'(vecs[i].e_cyc));
            check($sformatf("v%0d_instrs", i),    64'(ins_a),       64'(vecs[i].e_ins));
        end

        // Mode 1: PC match at 0x40 with pc_valid every other cycle (instance a)
        start = 1'b1; halt_mode = 1'b1; halt_pc = 32'h40; pc_valid = 1'b0;
        tick();
        check("m1_restart_done", 64'(done_a), 64'd0);
        start = 1'b0; halt_mode = 1'b0;
        tick();
        tick();
        check("m1_core_up", 64'(core_nrst_a), 64'd1);
        for (int j = 0; j <= 16; j++) begin
            pc = 32'(4 * j); pc_valid = 1'b1;
            tick();
            if (j == 15) check("m1_not_done_early", 64'(done_a), 64'd0);
            if (j == 16) break;
            pc_valid = 1'b0;
            tick();
        end
        pc_valid = 1'b0;
        check("m1_done",      64'(done_a), 64'd1);
        check("m1_timed_out", 64'(to_a),   64'd0);
        check("m1_instrs",    64'(ins_a),  64'd17);
        check("m1_cycles",    64'(cyc_a),  64'd33);

        // Timeout after 10 RUN cycles on instance b
        start = 1'b1; halt_mode = 1'b0;
        tick();
        start = 1'b0;
        tick();
        tick();
        for (int i = 1; i <= 10; i++) begin
            pc = 32'h2000 + 32'(4 * i); pc_valid = 1'b1;
            tick();
            if (i == 9) check("to_not_yet", 64'(to_b), 64'd0);
        end
        pc_valid = 1'b0;
        check("to_timed_out", 64'(to_b),   64'd1);
        check("to_done",      64'(done_b), 64'd0);
        check("to_busy",      64'(busy_b), 64'd0);
        check("to_cycles",    64'(cyc_b),  64'd10);
        check("to_instrs",    64'(ins_b),  64'd10);
        tick();
        check("to_frozen", 64'(cyc_b), 64'd10);

        // Restart from TIMEOUT in mode 1 with halt at 0x100
        start = 1'b1; halt_mode = 1'b1; halt_pc = 32'h100;
        tick();
        start = 1'b0; halt_mode = 1'b0; halt_pc = '0;
        check("rs_timed_out", 64'(to_b),        64'd0);
        check("rs_cycles",    64'(cyc_b),       64'd0);
        check("rs_instrs",    64'(ins_b),       64'd0);
        check("rs_core_nrst", 64'(core_nrst_b), 64'd0);
        check("rs_busy",      64'(busy_b),      64'd1);
        tick();
        tick();
        check("rs_core_up", 64'(core_nrst_b), 64'd1);

        // Halt on the 10th RUN cycle collides with timeout; start mid-run is ignored
        for (int i = 1; i <= 9; i++) begin
            pc = 32'h3000 + 32'(4 * i); pc_valid = 1'b1; start = (i == 5);
            tick();
        end
        start = 1'b0;
        check("hc_busy",   64'(busy_b), 64'd1);
        check("hc_cycles", 64'(cyc_b),  64'd9);
        pc = 32'h100; pc_valid = 1'b1;
        tick();
        pc_valid = 1'b0;
        check("hc_done",      64'(done_b), 64'd1);
        check("hc_timed_out", 64'(to_b),   64'd0);
        check("hc_cycles10",  64'(cyc_b),  64'd10);
        check("hc_instrs",    64'(ins_b),  64'd10);

        // Asynchronous reset while instance a is still running
        check("ar_pre_busy", 64'(busy_a), 64'd1);
        nrst = 1'b0;
        #2;
        check("ar_core_nrst", 64'(core_nrst_a), 64'd0);
        check("ar_busy",      64'(busy_a),      64'd0);
        check("ar_cycles",    64'(cyc_a),       64'd0);
        check("ar_instrs",    64'(ins_a),       64'd0);
        check("ar_done_b",    64'(done_b),      64'd0);
        tick();
        nrst = 1'b1;
        tick();
        check("ar_idle_busy",      64'(busy_a),      64'd0);
        check("ar_idle_core_nrst", 64'(core_nrst_a), 64'd0);

        // Saturation of 4-bit counts on instance c
        start = 1'b1; halt_mode = 1'b0;
        tick();
        start = 1'b0;
        tick();
        tick();
        for (int i = 1; i <= 15; i++) begin
            pc = 32'h5000 + 32'(4 * i); pc_valid = 1'b1;
            tick();
        end
        check("sat_cycles15", 64'(cyc_c),  64'd15);
        check("sat_instrs15", 64'(ins_c),  64'd15);
        check("sat_busy",     64'(busy_c), 64'd1);
        pc = 32'h6000;
        tick();
        pc_valid = 1'b0;
        check("sat_cycles_hold", 64'(cyc_c), 64'd15);
        check("sat_instrs_hold", 64'(ins_c), 64'd15);
        check("sat_timed_out",   64'(to_c),  64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
